spi_regfile: RTL

SPI_REGFILE -- requirements
Module: spi_regfile

---
 rtl/gsc_pkg.sv | 13 +
 rtl/sync2.sv | 24 ++
 rtl/spi_regfile.sv | 133 +++++++++++++
 3 files changed

// File: rtl/gsc_pkg.sv
// Shared defaults and FSM state encoding for the SPI register file.
package gsc_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for one asynchronous bit; RST_VAL sets the idle level
// both stages take during reset. Latency 2 clk, no backpressure.
module sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/spi_regfile.sv
// SPI-written register file: a valid frame updates reg_q/wr_stb within 4 clk of spi_cs rising.
// No backpressure; define SPI_READBACK_EN to shift the addressed register out on spi_miso.
module spi_regfile
  import gsc_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          spi_cs,
  input  logic                          spi_clk,
  input  logic                          spi_mosi,
  input  logic [ADDR_W-1:0]             spi_a,
  output logic [(2**ADDR_W)*DATA_W-1:0] reg_q,
  output logic [(2**ADDR_W)-1:0]        wr_stb,
  output logic                          frame_err,
  output logic                          busy,
  output logic                          spi_miso
);

  localparam int REG_CNT = 2**ADDR_W;
  localparam int CNT_W   = $clog2(DATA_W + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(DATA_W + 1);

  logic              cs_s, sclk_s, mosi_s;
  logic [ADDR_W-1:0] a_s;
  logic              cs_d, sclk_d;
  logic [1:0]        flush_q;
  logic              armed_q, pend_q;
  state_t            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] sh_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] regs [REG_CNT];
  logic              cs_fall, cs_rise, sclk_rise, start;

  sync2 #(.RST_VAL(1'b1)) u_sync_cs   (.clk(clk), .reset_n(reset_n), .d(spi_cs),   .q(cs_s));
  sync2 #(.RST_VAL(1'b1)) u_sync_sclk (.clk(clk), .reset_n(reset_n), .d(spi_clk),  .q(sclk_s));
  sync2 #(.RST_VAL(1'b0)) u_sync_mosi (.clk(clk), .reset_n(reset_n), .d(spi_mosi), .q(mosi_s));

  for (genvar i = 0; i < ADDR_W; i++) begin : g_sync_a
    sync2 #(.RST_VAL(1'b0)) u_sync_a (.clk(clk), .reset_n(reset_n), .d(spi_a[i]), .q(a_s[i]));
  end

  assign cs_fall   = cs_d & ~cs_s;
  assign cs_rise   = ~cs_d & cs_s;
  assign sclk_rise = ~sclk_d & sclk_s;
  // armed_q blocks a frame when spi_cs was already low as reset released
  assign start     = (state_q == ST_IDLE) && armed_q && (cs_fall || pend_q);
  assign busy      = (state_q == ST_SHIFT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cs_d      <= 1'b1;
      sclk_d    <= 1'b1;
      flush_q   <= 2'd0;
      armed_q   <= 1'b0;
      pend_q    <= 1'b0;
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      sh_q      <= '0;
      cnt_q     <= '0;
      wr_stb    <= '0;
      frame_err <= 1'b0;
      for (int k = 0; k < REG_CNT; k++) regs[k] <= '0;
    end else begin
      cs_d      <= cs_s;
      sclk_d    <= sclk_s;
      wr_stb    <= '0;
      frame_err <= 1'b0;
      if (flush_q != 2'd3) flush_q <= flush_q + 2'd1;
      else if (cs_s)       armed_q <= 1'b1;

      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_SHIFT;
            addr_q  <= a_s;
            sh_q    <= '0;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
          end
        end
        ST_SHIFT: begin
          // a clock edge landing with the closing spi_cs edge is dropped
          if (cs_rise) begin
            state_q <= (cnt_q == CNT_FULL) ? ST_COMMIT : ST_IDLE;
            if (cnt_q != CNT_FULL) frame_err <= 1'b1;
          end else if (sclk_rise) begin
            sh_q <= {sh_q[DATA_W-2:0], mosi_s};
            if (cnt_q != CNT_SAT) cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_COMMIT: begin
          regs[addr_q] <= sh_q;
          wr_stb       <= REG_CNT'(1) << addr_q;
          state_q      <= ST_IDLE;
          if (cs_fall) pend_q <= 1'b1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  for (genvar k = 0; k < REG_CNT; k++) begin : g_reg_q
    assign reg_q[k*DATA_W +: DATA_W] = regs[k];
  end

`ifdef SPI_READBACK_EN
  logic [DATA_W-1:0] tx_q;
  logic              sclk_fall;

  assign sclk_fall = sclk_d & ~sclk_s;

  // the leading falling edge carries the MSB already on the pin, so it does not shift
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_q <= '0;
    end else if (start) begin
      tx_q <= regs[a_s];
    end else if (busy && !cs_rise && sclk_fall && (cnt_q != '0)) begin
      tx_q <= {tx_q[DATA_W-2:0], 1'b0};
    end
  end

  assign spi_miso = busy & tx_q[DATA_W-1];
`else
  assign spi_miso = 1'b0;
`endif

endmodule
